// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the 5-stage pipeline and pipeline_hazard_ctrl.
// The pipeline side (master) reports stage status, and the controller (slave) returns hold/flush controls.
interface pipeline_hazard_ctrl_if;
    logic       mem_read_EX;
    logic [4:0] rd_EX;
    logic [4:0] rs1_ID;
    logic [4:0] rs2_ID;
    logic       uses_rs2_ID;
    logic       branch_taken_EX;
    logic       mem_req_MEM;
    logic       mem_ready;

    logic       pc_write;
    logic       if_id_write;
    logic       id_ex_write;
    logic       ex_mem_write;
    logic       if_id_flush;
    logic       id_ex_bubble;
    logic       mem_timeout;
    logic [1:0] state;

    modport master (
        output mem_read_EX, rd_EX, rs1_ID, rs2_ID, uses_rs2_ID,
               branch_taken_EX, mem_req_MEM, mem_ready,
        input  pc_write, if_id_write, id_ex_write, ex_mem_write,
               if_id_flush, id_ex_bubble, mem_timeout, state
    );

    modport slave (
        input  mem_read_EX, rd_EX, rs1_ID, rs2_ID, uses_rs2_ID,
               branch_taken_EX, mem_req_MEM, mem_ready,
        output pc_write, if_id_write, id_ex_write, ex_mem_write,
               if_id_flush, id_ex_bubble, mem_timeout, state
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall sequencer for the 5-stage pipeline: load-use stalls, taken-branch flushes, data-memory waits.
// Optional HAZARD_STATS_EN adds saturating stall-cycle and flush counters.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15
`ifdef HAZARD_STATS_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic                    clk,
    input  logic                    rst_n,
    pipeline_hazard_ctrl_if.slave   hz
`ifdef HAZARD_STATS_EN
    , output logic [CNT_W-1:0]      stall_cycles
    , output logic [CNT_W-1:0]      flush_count
`endif
);

    typedef enum logic [1:0] {
        RUN        = 2'b00,
        LOAD_STALL = 2'b01,
        MEM_WAIT   = 2'b10,
        FLUSH      = 2'b11
    } state_e;

    localparam int             WCW     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCW-1:0] WaitMax = WCW'(MEM_TIMEOUT);

    state_e         state_q, state_d;
    logic [WCW-1:0] waitCnt_q, waitCnt_d;
    logic           memTimeout_q, memTimeout_d;

    logic memHazard, loadUse;
    logic allowMem, allowDecode, holdWait, branchFlush;
    logic pcWrite, ifIdWrite, idExWrite, exMemWrite, ifIdFlush, idExBubble;

    assign memHazard = hz.mem_req_MEM && !hz.mem_ready;
    assign loadUse   = hz.mem_read_EX && (hz.rd_EX != 5'd0) &&
                       ((hz.rd_EX == hz.rs1_ID) || (hz.uses_rs2_ID && (hz.rd_EX == hz.rs2_ID)));

    // FLUSH only honours memory waits; the release cycle of MEM_WAIT decodes branch/load-use only.
    always_comb begin
        allowMem    = 1'b0;
        allowDecode = 1'b0;
        holdWait    = 1'b0;
        case (state_q)
            RUN, LOAD_STALL: begin
                allowMem    = 1'b1;
                allowDecode = 1'b1;
            end
            MEM_WAIT: begin
                holdWait    = !hz.mem_ready;
                allowDecode = hz.mem_ready;
            end
            FLUSH: allowMem = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        pcWrite     = 1'b1;
        ifIdWrite   = 1'b1;
        idExWrite   = 1'b1;
        exMemWrite  = 1'b1;
        ifIdFlush   = 1'b0;
        idExBubble  = 1'b0;
        branchFlush = 1'b0;
        state_d     = RUN;
        if (holdWait || (allowMem && memHazard)) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            idExWrite  = 1'b0;
            exMemWrite = 1'b0;
            state_d    = MEM_WAIT;
        end else if (allowDecode && hz.branch_taken_EX) begin
            ifIdFlush   = 1'b1;
            idExBubble  = 1'b1;
            branchFlush = 1'b1;
            state_d     = FLUSH;
        end else if (allowDecode && loadUse) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            idExBubble = 1'b1;
            state_d    = LOAD_STALL;
        end
    end

    // wait_cnt counts not-ready cycles of the current access, including the one that entered MEM_WAIT.
    always_comb begin
        waitCnt_d = '0;
        if (state_d == MEM_WAIT) begin
            if (state_q != MEM_WAIT)
                waitCnt_d = WCW'(1);
            else if (waitCnt_q == WaitMax)
                waitCnt_d = WaitMax;
            else
                waitCnt_d = waitCnt_q + WCW'(1);
        end
        memTimeout_d = memTimeout_q || (waitCnt_d == WaitMax);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            waitCnt_q    <= '0;
            memTimeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            waitCnt_q    <= waitCnt_d;
            memTimeout_q <= memTimeout_d;
        end
    end

    assign hz.pc_write     = rst_n && pcWrite;
    assign hz.if_id_write  = rst_n && ifIdWrite;
    assign hz.id_ex_write  = rst_n && idExWrite;
    assign hz.ex_mem_write = rst_n && exMemWrite;
    assign hz.if_id_flush  = !rst_n || ifIdFlush;
    assign hz.id_ex_bubble = !rst_n || idExBubble;
    assign hz.mem_timeout  = memTimeout_q;
    assign hz.state        = state_q;

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stallCycles_q, flushCount_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCycles_q <= '0;
            flushCount_q  <= '0;
        end else begin
            if (!pcWrite && (stallCycles_q != '1))
                stallCycles_q <= stallCycles_q + CNT_W'(1);
            if (branchFlush && (flushCount_q != '1))
                flushCount_q <= flushCount_q + CNT_W'(1);
        end
    end

    assign stall_cycles = stallCycles_q;
    assign flush_count  = flushCount_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed hazard scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;

    localparam int MEM_TIMEOUT = 15;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    // Model: phase holds the state code the controller should be in; nrCount holds not-ready cycles of the current access.
    int   mdlPhase;
    int   mdlNrCount;
    bit   mdlTimeout;
    int   mdlStalls;
    int   mdlFlushes;

    pipeline_hazard_ctrl_if hz ();

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
`endif

    pipeline_hazard_ctrl #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hz           (hz)
`ifdef HAZARD_STATS_EN
        , .stall_cycles (stall_cycles)
        , .flush_count  (flush_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic setIdle();
        hz.mem_read_EX     = 1'b0;
        hz.rd_EX           = 5'd0;
        hz.rs1_ID          = 5'd0;
        hz.rs2_ID          = 5'd0;
        hz.uses_rs2_ID     = 1'b0;
        hz.branch_taken_EX = 1'b0;
        hz.mem_req_MEM     = 1'b0;
        hz.mem_ready       = 1'b1;
    endtask

    // One pipeline cycle: drive at negedge, compare mid-cycle, then advance the model across the posedge.
    task automatic applyStimulus(input bit memRead, input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input bit uses2, input bit br,
                                 input bit req, input bit rdy);
        bit ePc, eIf, eId, eEx, eFl, eBub, memMiss, loadDep, waiting, flushing;
        int nextPhase;
        @(negedge clk);
        hz.mem_read_EX     = memRead;
        hz.rd_EX           = rd;
        hz.rs1_ID          = rs1;
        hz.rs2_ID          = rs2;
        hz.uses_rs2_ID     = uses2;
        hz.branch_taken_EX = br;
        hz.mem_req_MEM     = req;
        hz.mem_ready       = rdy;
        #2;
        ePc = 1; eIf = 1; eId = 1; eEx = 1; eFl = 0; eBub = 0;
        nextPhase = 0;
        waiting   = (mdlPhase == 2);
        flushing  = (mdlPhase == 3);
        memMiss   = req && !rdy;
        loadDep   = memRead && (rd != 0) && ((rd == rs1) || (uses2 && (rd == rs2)));
        if ((waiting && !rdy) || (!waiting && memMiss)) begin
            ePc = 0; eIf = 0; eId = 0; eEx = 0;
            nextPhase = 2;
        end else if (!flushing && br) begin
            eFl = 1; eBub = 1;
            nextPhase = 3;
            mdlFlushes++;
        end else if (!flushing && loadDep) begin
            ePc = 0; eIf = 0; eBub = 1;
            nextPhase = 1;
        end
        checkOutput("pc_write",     hz.pc_write,     ePc);
        checkOutput("if_id_write",  hz.if_id_write,  eIf);
        checkOutput("id_ex_write",  hz.id_ex_write,  eId);
        checkOutput("ex_mem_write", hz.ex_mem_write, eEx);
        checkOutput("if_id_flush",  hz.if_id_flush,  eFl);
        checkOutput("id_ex_bubble", hz.id_ex_bubble, eBub);
        checkOutput("state",        hz.state,        mdlPhase);
        checkOutput("mem_timeout",  hz.mem_timeout,  mdlTimeout);
        if (!ePc) mdlStalls++;
        if (nextPhase == 2) mdlNrCount = waiting ? mdlNrCount + 1 : 1;
        else                mdlNrCount = 0;
        if (mdlNrCount >= MEM_TIMEOUT) mdlTimeout = 1;
        mdlPhase = nextPhase;
        @(posedge clk);
    endtask

    task automatic idleCycle();
        applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1);
    endtask

    // Asynchronous reset mid-cycle; forced outputs must appear immediately.
    task automatic doReset();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst pc_write",     hz.pc_write,     0);
        checkOutput("rst if_id_write",  hz.if_id_write,  0);
        checkOutput("rst id_ex_write",  hz.id_ex_write,  0);
        checkOutput("rst ex_mem_write", hz.ex_mem_write, 0);
        checkOutput("rst if_id_flush",  hz.if_id_flush,  1);
        checkOutput("rst id_ex_bubble", hz.id_ex_bubble, 1);
        checkOutput("rst state",        hz.state,        0);
        checkOutput("rst mem_timeout",  hz.mem_timeout,  0);
`ifdef HAZARD_STATS_EN
        checkOutput("rst stall_cycles", stall_cycles, 0);
        checkOutput("rst flush_count",  flush_count,  0);
`endif
        setIdle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n      = 1'b1;
        mdlPhase   = 0;
        mdlNrCount = 0;
        mdlTimeout = 0;
        mdlStalls  = 0;
        mdlFlushes = 0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        setIdle();
        doReset();

        // Load-use on rs1, then the same pattern with rd_EX = 0.
        applyStimulus(1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 1);
        idleCycle();
        idleCycle();
        applyStimulus(1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 1);
        idleCycle();

        // rs2 match only counts when the ID instruction reads rs2.
        applyStimulus(1, 5'd7, 5'd1, 5'd7, 0, 0, 0, 1);
        applyStimulus(1, 5'd7, 5'd1, 5'd7, 1, 0, 0, 1);
        idleCycle();

        // Taken branch, then a load-use match during FLUSH that must be ignored.
        applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 1);
        applyStimulus(1, 5'd9, 5'd9, 5'd0, 0, 0, 0, 1);
        idleCycle();

        // Long memory wait crossing the timeout, then release.
        for (int i = 0; i < 20; i++) applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
        applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1);
        idleCycle();
        idleCycle();

        // Memory wait with a branch held in EX: wait first, flush on release.
        for (int i = 0; i < 3; i++) applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0);
        applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 1);
        idleCycle();

        // Reset in the middle of a wait.
        for (int i = 0; i < 4; i++) applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
        doReset();
        idleCycle();

        for (int i = 0; i < 1500; i++) begin
            applyStimulus($urandom_range(0, 1), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)), $urandom_range(0, 1),
                          ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 3; i++) applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
        applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1);

`ifdef HAZARD_STATS_EN
        checkOutput("stall_cycles random", stall_cycles, mdlStalls);
        checkOutput("flush_count random",  flush_count,  mdlFlushes);
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 5'd3, 5'd3, 5'd0, 0, 0, 0, 1);
            idleCycle();
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 1);
            idleCycle();
        end
        #1;
        checkOutput("stall_cycles", stall_cycles, 3);
        checkOutput("flush_count",  flush_count,  2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and stall sequencer for the 5-stage pipeline. It watches the ID, EX and MEM stages and drives the write enables, flushes and bubble-inserts of the PC and of the IF/ID, ID/EX and EX/MEM pipeline registers. It covers three cases: load-use hazards, taken branches and multi-cycle data-memory accesses. The block sits beside the pipeline registers and is their only source of hold/flush control.

## Interface
- MEM_TIMEOUT, 15: `MEM_WAIT` cycles after which `mem_timeout` is raised.
- CNT_W, 32: width of the statistics counters (present only with `HAZARD_STATS_EN`).

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- mem_read_EX  in  1  instruction in EX is a load.
- rd_EX  in  5  destination register of the EX instruction.
- rs1_ID  in  5  source register 1 of the ID instruction.
- rs2_ID  in  5  source register 2 of the ID instruction.
- uses_rs2_ID  in  1  ID instruction reads rs2.
- branch_taken_EX  in  1  branch/jump resolved taken in EX.
- mem_req_MEM  in  1  MEM stage is accessing data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC load enable.
- if_id_write  out  1  IF/ID load enable.
- id_ex_write  out  1  ID/EX load enable.
- ex_mem_write  out  1  EX/MEM load enable.
- if_id_flush  out  1  load NOP into IF/ID.
- id_ex_bubble  out  1  load zero WB/MEM/EX control fields into ID/EX.
- mem_timeout  out  1  sticky error flag.
- state  out  2  current FSM state (debug).

## Operation
FSM states:
- `RUN` = 00
- `LOAD_STALL` = 01
- `MEM_WAIT` = 10
- `FLUSH` = 11

Outputs are combinational from the registered state and the current inputs. Defaults: all `*_write` = 1; `if_id_flush`, `id_ex_bubble` = 0.

Decode in `RUN` and `LOAD_STALL`, in strict priority order:
1. **Memory wait:** `mem_req_MEM && !mem_ready`.
   - All four `*_write` = 0.
   - Next state `MEM_WAIT`.
2. **Branch:** `branch_taken_EX`.
   - `if_id_flush` = 1, `id_ex_bubble` = 1, `pc_write` = 1 (loads target).
   - Next state `FLUSH`.
3. **Load-use:** `mem_read_EX && rd_EX != 0 && (rd_EX == rs1_ID || (uses_rs2_ID && rd_EX == rs2_ID))`.
   - `pc_write` = 0, `if_id_write` = 0, `id_ex_bubble` = 1.
   - Next state `LOAD_STALL`.
4. **Otherwise:** defaults, next state `RUN`.

`LOAD_STALL` is a one-cycle marker (EX now holds a bubble). It decodes exactly as `RUN`.

`MEM_WAIT`:
- While `mem_ready` = 0: all `*_write` = 0, stay in `MEM_WAIT`, `wait_cnt` increments (saturates at `MEM_TIMEOUT`).
- When `wait_cnt` reaches `MEM_TIMEOUT`: `mem_timeout` sets and holds until reset. Waiting continues; there is no abort.
- On the `mem_ready` = 1 cycle: decode as `RUN` priorities 2–4, except that a new memory wait is not re-entered in that cycle. `wait_cnt` clears.
- A branch or load held in EX during the wait is handled on that release cycle.

`FLUSH`:
- One cycle. Priority 1 (memory wait) applies.
- Branch and load-use decode are suppressed, because ID and EX hold bubbles. Defaults otherwise.
- Next state `RUN` (or `MEM_WAIT` via priority 1).

A hazard involving `rd_EX` = 0 is never a hazard.

## Timing
- **Reset** (asynchronous on `rst_n` low):
  - State `RUN`, `wait_cnt` 0, `mem_timeout` 0, statistics counters 0.
  - While `rst_n` = 0, outputs are forced to: all `*_write` = 0, `if_id_flush` = 1, `id_ex_bubble` = 1.
  - Reset asserted mid-`MEM_WAIT` abandons the wait immediately.
- **Latency:** control outputs respond in the same cycle as the inputs. The state change is visible at the next rising edge.
- **Load-use** costs exactly 1 stall cycle.
- **Taken branch** costs 2 squashed instructions and 1 `FLUSH` cycle.
- **Memory wait:** a memory access with N not-ready cycles stalls for exactly N cycles.
- **Simultaneous events** resolve by the priority order above.

## Configuration
`HAZARD_STATS_EN` adds two outputs:
- `stall_cycles [CNT_W-1:0]`: counts cycles with `pc_write` = 0.
- `flush_count [CNT_W-1:0]`: counts branch flushes.

Both counters saturate at all-ones and clear on reset. When the macro is undefined, these ports and counters are absent and the remaining behaviour is identical.

## Test plan
- **Load-use:** `mem_read_EX` = 1, `rd_EX` = 5, `rs1_ID` = 5 → for 1 cycle `pc_write` = 0, `if_id_write` = 0, `id_ex_bubble` = 1, `state` → 01, then `RUN`. Repeat with `rd_EX` = 0 → no stall.
- **rs2 qualification:** `rd_EX` = 7, `rs2_ID` = 7, `uses_rs2_ID` = 0 → no stall; `uses_rs2_ID` = 1 → stall.
- **Branch:** `branch_taken_EX` = 1 → `if_id_flush` = 1, `id_ex_bubble` = 1, `pc_write` = 1, `state` = 11 next cycle. A load-use match during `FLUSH` is ignored.
- **Memory wait with timeout:** `mem_req_MEM` = 1, `mem_ready` low 20 cycles (`MEM_TIMEOUT` = 15) → all writes 0 for 20 cycles, `mem_timeout` set after cycle 15 and stays set. Writes resume on the `mem_ready` cycle.
- **Simultaneous events and reset:** memory wait + branch asserted together → `MEM_WAIT` first, flush on the release cycle. Separately, drop `rst_n` mid-`MEM_WAIT` → `state` = 00 and forced reset outputs immediately.
- **Statistics** (with `HAZARD_STATS_EN`): 3 load-use stalls + 2 branches → `stall_cycles` = 3, `flush_count` = 2.
